// File: rtl/i2s_dac_tx.sv
// I2S playback serializer for the WM8731 DAC path (codec is bus master).
// Optional I2S_DAC_HOLD_EN: on underrun repeat the previous sample instead of silence.
module i2s_dac_tx (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        AUD_BCLK,
    input  logic        AUD_DACLRCK,
    output logic        AUD_DACDAT,
    output logic        request_play_data,
    input  logic [15:0] play_data,
    input  logic        play_valid,
    output logic        underrun
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BIT = 2'd1,
        SHIFT    = 2'd2,
        PAD      = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  bclk_sync_q, lrck_sync_q;
    logic        bclk_prev_q, lrck_prev_q;
    logic [15:0] shift_q, shift_d;
    logic [15:0] last_q, last_d;
    logic [15:0] hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic        bit_q, bit_d;
    logic [3:0]  cnt_q, cnt_d;

    logic bclk_fall, lrck_fall, lrck_rise, accept;

    assign bclk_fall = bclk_prev_q & ~bclk_sync_q[1];
    assign lrck_fall = lrck_prev_q & ~lrck_sync_q[1];
    assign lrck_rise = ~lrck_prev_q & lrck_sync_q[1];
    assign accept    = play_valid & request_play_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bclk_sync_q <= '0;
            lrck_sync_q <= '0;
            bclk_prev_q <= 1'b0;
            lrck_prev_q <= 1'b0;
            shift_q     <= '0;
            last_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bit_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            bclk_sync_q <= {bclk_sync_q[0], AUD_BCLK};
            lrck_sync_q <= {lrck_sync_q[0], AUD_DACLRCK};
            bclk_prev_q <= bclk_sync_q[1];
            lrck_prev_q <= lrck_sync_q[1];
            shift_q     <= shift_d;
            last_q      <= last_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            bit_q       <= bit_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        last_d      = last_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        bit_d       = bit_q;
        cnt_d       = cnt_q;
        if (!enable) begin
            state_d     = IDLE;
            hold_full_d = 1'b0;
            last_d      = '0;
        end else begin
            if (accept) begin
                hold_d      = play_data;
                hold_full_d = 1'b1;
            end
            // LRCK edges win over a coincident BCLK fall: that fall is the
            // I2S delay slot, the MSB goes out on the following one.
            if (lrck_fall) begin
                state_d = WAIT_BIT;
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    last_d      = hold_q;
                    hold_full_d = 1'b0;
                end else begin
`ifdef I2S_DAC_HOLD_EN
                    shift_d = last_q;
`else
                    shift_d = '0;
                    last_d  = '0;
`endif
                end
            end else if (lrck_rise && state_q != IDLE) begin
                state_d = WAIT_BIT;
                shift_d = last_q;
            end else if (bclk_fall) begin
                unique case (state_q)
                    WAIT_BIT: begin
                        state_d = SHIFT;
                        bit_d   = shift_q[15];
                        shift_d = {shift_q[14:0], 1'b0};
                        cnt_d   = 4'd15;
                    end
                    SHIFT: begin
                        if (cnt_q == 4'd0) begin
                            state_d = PAD;
                        end else begin
                            bit_d   = shift_q[15];
                            shift_d = {shift_q[14:0], 1'b0};
                            cnt_d   = cnt_q - 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        AUD_DACDAT        = enable & (state_q == SHIFT) & bit_q;
        request_play_data = enable & ~hold_full_q & ~rst;
        underrun          = enable & lrck_fall & ~hold_full_q;
    end

endmodule
